// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//   Measures the frequency of an asynchronous input. Rising edges of sig_in
//   are counted over a gate window of GATE_CYCLES clk cycles. Each completed
//   window publishes one count.
//
//   Window timeline: ARM (1 cycle) -> GATE (GATE_CYCLES cycles) -> LATCH
//   (1 cycle). This gives a period of GATE_CYCLES+2 cycles when en stays high.
//   Edges that land in ARM or LATCH are not counted.
//
// Parameters
//   GATE_CYCLES  clk cycles per gate window (must be >= CNT_W+4)
//   CNT_W        width of the edge counter and freq_count
//
// Ports
//   clk         global clock, all logic on posedge
//   rst         synchronous reset, active-high
//   en          1 = measure continuously, 0 = abort / stop
//   sig_in      asynchronous signal under measurement
//   freq_count  edges counted in the last completed window
//   valid       one-cycle pulse when freq_count updates
//   overflow    last window's edge counter saturated
//   busy        high whenever the FSM is not idle
//   bcd_out     8 BCD digits of freq_count (BCD_OUT_EN only)
//   bcd_valid   one-cycle pulse when bcd_out updates (BCD_OUT_EN only)
//
// Configuration
//   BCD_OUT_EN  When defined, adds a sequential double-dabble converter and
//               the bcd_out/bcd_valid ports. Without it, the rest of the
//               block is identical.
// ---------------------------------------------------------------------------
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
`ifdef BCD_OUT_EN
  ,
  output logic [31:0]      bcd_out,
  output logic             bcd_valid
`endif
);

  localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             edge_det;

  // -------------------------------------------------------------------------
  // Next-state logic: synchronizer, gate timer, edge counter, FSM
  // -------------------------------------------------------------------------
  always_comb begin
    // s1/s2 form the metastability synchronizer. s3 delays s2 by one cycle
    // so that a rising edge is seen as s2 & ~s3.
    s1_d     = sig_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    edge_det = s2_q & ~s3_q;

    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    freq_d   = freq_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ARM;
      end

      ST_ARM: begin
        tmr_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = en ? ST_GATE : ST_IDLE;
      end

      ST_GATE: begin
        if (!en) begin
          // Abort: the partial count is discarded. freq_count keeps the
          // value from the last completed window.
          state_d = ST_IDLE;
        end else begin
          // Saturate instead of wrapping. An edge arriving at full scale is
          // a lost edge, so it marks this window as overflowed.
          if (edge_det) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
          end
          if (tmr_q == TMR_LAST) state_d = ST_LATCH;
          else                   tmr_d   = tmr_q + TMR_W'(1);
        end
      end

      ST_LATCH: begin
        freq_d  = cnt_q;
        ovf_d   = sat_q;
        valid_d = 1'b1;
        state_d = en ? ST_ARM : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // busy is registered from the next state, so it follows state_q exactly.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign freq_count = freq_q;
  assign valid      = valid_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

`ifdef BCD_OUT_EN
  // -------------------------------------------------------------------------
  // Sequential double-dabble converter.
  //   The value being published is loaded on the LATCH cycle. The converter
  //   then runs CNT_W adjust+shift cycles, one result cycle, and then pulses
  //   bcd_valid. Window spacing (>= CNT_W+6 cycles) keeps conversions from
  //   overlapping. A new load would simply restart the conversion.
  //   Only rst cancels a conversion; an abort or en=0 does not.
  // -------------------------------------------------------------------------
  localparam int unsigned      CSW       = $clog2(CNT_W + 1);
  localparam logic [63:0]      BCD_LIMIT = 64'd99_999_999;

  logic             conv_act_q, conv_act_d;
  logic             conv_done_q, conv_done_d;
  logic [CSW-1:0]   conv_cnt_q, conv_cnt_d;
  logic [CNT_W-1:0] bin_q, bin_d;
  logic [31:0]      wk_q, wk_d;
  logic             clamp_q, clamp_d;
  logic [31:0]      bcd_out_q, bcd_out_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [31:0]      wk_adj;

  always_comb begin
    // Add-3 correction on every digit >= 5 before the shift.
    wk_adj = wk_q;
    for (int i = 0; i < 8; i++) begin
      if (wk_q[4*i +: 4] >= 4'd5) wk_adj[4*i +: 4] = wk_q[4*i +: 4] + 4'd3;
    end

    conv_act_d  = conv_act_q;
    conv_done_d = conv_done_q;
    conv_cnt_d  = conv_cnt_q;
    bin_d       = bin_q;
    wk_d        = wk_q;
    clamp_d     = clamp_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;

    if (state_q == ST_LATCH) begin
      conv_act_d  = 1'b1;
      conv_done_d = 1'b0;
      conv_cnt_d  = '0;
      bin_d       = cnt_q;
      wk_d        = '0;
      // Eight digits cannot show more than 99_999_999, so the result is
      // pinned to all nines.
      clamp_d     = ({{(64-CNT_W){1'b0}}, cnt_q} > BCD_LIMIT);
    end else if (conv_act_q) begin
      wk_d  = {wk_adj[30:0], bin_q[CNT_W-1]};
      bin_d = bin_q << 1;
      if (conv_cnt_q == CSW'(CNT_W - 1)) begin
        conv_act_d  = 1'b0;
        conv_done_d = 1'b1;
      end else begin
        conv_cnt_d = conv_cnt_q + CSW'(1);
      end
    end else if (conv_done_q) begin
      conv_done_d = 1'b0;
      bcd_out_d   = clamp_q ? 32'h9999_9999 : wk_q;
      bcd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_act_q  <= 1'b0;
      conv_done_q <= 1'b0;
      conv_cnt_q  <= '0;
      bin_q       <= '0;
      wk_q        <= '0;
      clamp_q     <= 1'b0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      conv_act_q  <= conv_act_d;
      conv_done_q <= conv_done_d;
      conv_cnt_q  <= conv_cnt_d;
      bin_q       <= bin_d;
      wk_q        <= wk_d;
      clamp_q     <= clamp_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
`endif

endmodule
